// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx serializer among N_REQ byte requesters,
// with a watchdog that aborts a transfer whose Tx_Done never arrives.
module uart_tx_sched #(
  parameter int N_REQ   = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 100000,
  parameter int TOW     = 17
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [2:0]         baud_cfg,
  output logic [N_REQ-1:0]   ack,
  output logic               err,
  output logic               busy,
  output logic [IDW-1:0]     cur_id,
  output logic               Send_en,
  output logic [7:0]         data_byte,
  output logic [2:0]         baud_Set,
  input  logic               Tx_Done,
  output logic [1:0]         state_dbg
);

  // Handshake: req[i] is a level held (with stable req_data) until ack[i] or err
  // with cur_id==i; Send_en and Tx_Done are single-cycle pulses toward/from uart_tx.
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ-1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT-1);

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [TOW-1:0] wd, wd_nxt;
  logic [IDW-1:0] win;
  logic [IDW-1:0] id_after;
  logic           timed_out;

  logic [N_REQ-1:0] ack_nxt;
  logic             err_nxt, busy_nxt, send_nxt;
  logic [IDW-1:0]   id_nxt;
  logic [7:0]       data_nxt;
  logic [2:0]       baud_nxt;

  assign state_dbg = state;
  assign timed_out = (wd == TO_LAST);
  assign id_after  = (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;

  // First set request searching upward from ptr, wrapping at N_REQ.
  always_comb begin
    logic         found;
    logic [IDW:0] sum;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && req[sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = sum[IDW-1:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (|req) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (Tx_Done || timed_out) state_nxt = S_GAP;
      S_GAP:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; Tx_Done takes priority over the watchdog.
  always_comb begin
    ack_nxt  = '0;
    err_nxt  = 1'b0;
    send_nxt = 1'b0;
    busy_nxt = (state_nxt != S_IDLE);
    id_nxt   = cur_id;
    data_nxt = data_byte;
    baud_nxt = baud_Set;
    ptr_nxt  = ptr;
    wd_nxt   = wd;
    case (state)
      S_IDLE: begin
        if (|req) begin
          id_nxt   = win;
          data_nxt = req_data[{win, 3'b000} +: 8];
          baud_nxt = baud_cfg;
        end
      end
      S_LAUNCH: begin
        send_nxt = 1'b1;
        wd_nxt   = '0;
      end
      S_WAIT: begin
        wd_nxt = wd + 1'b1;
        if (Tx_Done) begin
          ack_nxt[cur_id] = 1'b1;
          ptr_nxt         = id_after;
        end else if (timed_out) begin
          err_nxt = 1'b1;
          ptr_nxt = id_after;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ack       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      Send_en   <= 1'b0;
      cur_id    <= '0;
      data_byte <= 8'h00;
      baud_Set  <= 3'd0;
      ptr       <= '0;
      wd        <= '0;
    end else begin
      ack       <= ack_nxt;
      err       <= err_nxt;
      busy      <= busy_nxt;
      Send_en   <= send_nxt;
      cur_id    <= id_nxt;
      data_byte <= data_nxt;
      baud_Set  <= baud_nxt;
      ptr       <= ptr_nxt;
      wd        <= wd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: the bench plays the uart_tx side and checks
// each grant against an expected queue of {id, byte, baud} tuples.
module tb_uart_tx_sched;

  logic        Clk;
  logic        Rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [2:0]  baud_cfg;
  logic [3:0]  ack;
  logic        err;
  logic        busy;
  logic [1:0]  cur_id;
  logic        Send_en;
  logic [7:0]  data_byte;
  logic [2:0]  baud_Set;
  logic        Tx_Done;
  logic [1:0]  state_dbg;

  logic [12:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int lat;
  int n;

  uart_tx_sched #(.N_REQ(4), .IDW(2), .TIMEOUT(50), .TOW(6)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req(req), .req_data(req_data), .baud_cfg(baud_cfg),
    .ack(ack), .err(err), .busy(busy), .cur_id(cur_id), .Send_en(Send_en),
    .data_byte(data_byte), .baud_Set(baud_Set), .Tx_Done(Tx_Done), .state_dbg(state_dbg)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic do_reset();
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_send"}, 32'(Send_en), 32'd0);
    check({tag, "_data"}, 32'(data_byte), 32'd0);
    check({tag, "_baud"}, 32'(baud_Set), 32'd0);
    check({tag, "_id"}, 32'(cur_id), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  function automatic logic [12:0] tup(input logic [1:0] id, input logic [2:0] baud);
    return {id, req_data[8*id +: 8], baud};
  endfunction

  // driver: act as uart_tx for one grant. mode 0 hold req, 1 drop req[id],
  // 2 drop req[id] for one cycle, 3 clear all requests after the ack.
  task automatic serve(input int mode, input bit give_done, input bit more,
                       input int new_baud, output int lat_o);
    logic [12:0] e;
    logic [1:0]  id;
    logic [3:0]  exp_ack;
    int          w;
    w = 0;
    while (Send_en !== 1'b1 && w < 40) begin
      @(negedge Clk);
      w++;
    end
    lat_o = w;
    check("send_seen", 32'(Send_en), 32'd1);
    if (Send_en !== 1'b1) return;
    if (exp_q.size() == 0) begin
      check("exp_q_nonempty", 32'd0, 32'd1);
      return;
    end
    e  = exp_q.pop_front();
    id = e[12:11];
    check("grant", 32'({cur_id, data_byte, baud_Set}), 32'(e));
    check("busy_xfer", 32'(busy), 32'd1);
    if (new_baud >= 0) baud_cfg = 3'(new_baud);
    @(negedge Clk);
    check("send_pulse", 32'(Send_en), 32'd0);
    if (!give_done) return;
    repeat ($urandom_range(2, 10)) @(negedge Clk);
    Tx_Done = 1'b1;
    @(negedge Clk);
    Tx_Done = 1'b0;
    exp_ack = 4'b0001 << id;
    check("ack", 32'(ack), 32'(exp_ack));
    check("err_quiet", 32'(err), 32'd0);
    check("stable", 32'({data_byte, baud_Set}), 32'(e[10:0]));
    if (mode == 1 || mode == 2) req[id] = 1'b0;
    else if (mode == 3) req = '0;
    @(negedge Clk);
    check("ack_clear", 32'(ack), 32'd0);
    check("busy_gap", 32'(busy), 32'd0);
    if (mode == 2) req[id] = 1'b1;
    if (more) begin
      @(negedge Clk);
      check("busy_next", 32'(busy), 32'd1);
    end
  endtask

  initial begin
    Rst_n = 1'b0; req = '0; req_data = '0; baud_cfg = 3'd0; Tx_Done = 1'b0;
    repeat (2) @(negedge Clk);
    check_reset_vals("rst_held");
    Rst_n = 1'b1;
    @(negedge Clk);
    check_reset_vals("rst_rel");

    // single request on channel 2
    req_data[23:16] = 8'hA5; baud_cfg = 3'd4; req = 4'b0100;
    exp_q.push_back(tup(2'd2, 3'd4));
    serve(1, 1'b1, 1'b0, -1, lat);
    check("single_latency", 32'(lat), 32'd2);

    // all four held: 0,1,2,3,0
    do_reset();
    req_data = 32'h13121110; baud_cfg = 3'd2; req = 4'b1111;
    exp_q.push_back(tup(2'd0, 3'd2));
    exp_q.push_back(tup(2'd1, 3'd2));
    exp_q.push_back(tup(2'd2, 3'd2));
    exp_q.push_back(tup(2'd3, 3'd2));
    exp_q.push_back(tup(2'd0, 3'd2));
    for (int i = 0; i < 4; i++) serve(0, 1'b1, 1'b1, -1, lat);
    serve(3, 1'b1, 1'b0, -1, lat);

    // fairness between channels 1 and 3 (ptr now 1)
    for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'($urandom_range(0, 255));
    baud_cfg = 3'd1; req = 4'b1010;
    exp_q.push_back(tup(2'd1, 3'd1));
    exp_q.push_back(tup(2'd3, 3'd1));
    exp_q.push_back(tup(2'd1, 3'd1));
    exp_q.push_back(tup(2'd3, 3'd1));
    for (int i = 0; i < 3; i++) serve(2, 1'b1, 1'b1, -1, lat);
    serve(3, 1'b1, 1'b0, -1, lat);

    // baud change mid-WAIT is held until next grant (ptr now 0)
    baud_cfg = 3'd4; req = 4'b0011;
    exp_q.push_back(tup(2'd0, 3'd4));
    exp_q.push_back(tup(2'd1, 3'd0));
    serve(1, 1'b1, 1'b1, 0, lat);
    serve(3, 1'b1, 1'b0, -1, lat);

    // watchdog: no Tx_Done for channel 2 (ptr now 2)
    baud_cfg = 3'd3; req = 4'b1100;
    exp_q.push_back(tup(2'd2, 3'd3));
    serve(0, 1'b0, 1'b0, -1, lat);
    n = 1;
    while (err !== 1'b1 && n < 100) begin
      check("wd_no_ack", 32'(ack), 32'd0);
      @(negedge Clk);
      n++;
    end
    check("wd_latency", 32'(n), 32'd50);
    check("wd_err_ack", 32'(ack), 32'd0);
    check("wd_err_id", 32'(cur_id), 32'd2);
    req[2] = 1'b0;
    @(negedge Clk);
    check("wd_err_clear", 32'(err), 32'd0);
    exp_q.push_back(tup(2'd3, 3'd3));
    serve(3, 1'b1, 1'b0, -1, lat);

    // reset mid-transfer, then channel 0 wins despite channel 2 pending
    req = 4'b0100;
    exp_q.push_back(tup(2'd2, 3'd3));
    serve(0, 1'b0, 1'b0, -1, lat);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    req = 4'b0101;
    @(negedge Clk);
    check("rst_mid_ack", 32'(ack), 32'd0);
    Rst_n = 1'b1;
    exp_q.push_back(tup(2'd0, 3'd3));
    serve(3, 1'b1, 1'b0, -1, lat);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
